// File: rtl/adder_pkg.sv
// Shared types for the prefix-adder result path: adder width and the buffered result record.
package adder_pkg;
  localparam int ADD_W = 6;

  typedef struct packed {
    logic             ov;
    logic [ADD_W-1:0] sum;
  } add_res_t;
endpackage

// File: rtl/res_fifo.sv
// Small synchronous FIFO of adder results with a registered head entry; no bypass from push to dout.
module res_fifo
  import adder_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  logic     pop,
  input  add_res_t din,
  output add_res_t dout,
  output logic     full,
  output logic     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PW-1:0] wr_ptr_next, rd_ptr_next;
  add_res_t      mem_reg [DEPTH];
  add_res_t      head_reg;
  logic          do_push, do_pop;

  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign wr_ptr_next = wr_ptr_reg + PW'(do_push);
  assign rd_ptr_next = rd_ptr_reg + PW'(do_pop);
  assign dout        = head_reg;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_reg[wr_ptr_reg[AW-1:0]] <= din;
    end
  end

  // The head register is preloaded with whatever will be at the front after this edge;
  // when the queue goes empty it keeps its last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      head_reg   <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      if (rd_ptr_next != wr_ptr_next) begin
        head_reg <= (rd_ptr_next == wr_ptr_reg) ? din : mem_reg[rd_ptr_next[AW-1:0]];
      end
    end
  end
endmodule

// File: rtl/adder_result_stage.sv
// Registered, FIFO-buffered output stage for the 6-bit prefix adder with a saturating ov counter.
// Build option: ADDER_RESULT_SATURATE_EN stores an all-ones sum for results with ov=1.
module adder_result_stage
  import adder_pkg::*;
#(
  parameter int WIDTH = ADD_W,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_sum,
  input  logic             in_ov,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_ov,
  input  logic             out_ready,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] ov_cnt
);
  add_res_t         fifo_din, fifo_dout;
  logic             fifo_full, fifo_empty;
  logic             push, pop;
  logic [CNT_W-1:0] ov_cnt_reg;

  assign in_ready  = !fifo_full;
  assign out_valid = !fifo_empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    fifo_din.ov = in_ov;
`ifdef ADDER_RESULT_SATURATE_EN
    fifo_din.sum = in_ov ? {WIDTH{1'b1}} : in_sum;
`else
    fifo_din.sum = in_sum;
`endif
  end

  res_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_sum = fifo_dout.sum;
  assign out_ov  = fifo_dout.ov;

  // Clear wins over a coincident ov push; the counter sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      ov_cnt_reg <= '0;
    end else if (push && in_ov && (ov_cnt_reg != {CNT_W{1'b1}})) begin
      ov_cnt_reg <= ov_cnt_reg + 1'b1;
    end
  end

  assign ov_cnt = ov_cnt_reg;
endmodule

// File: tb/tb_adder_result_stage.sv
// Scoreboard bench for adder_result_stage: directed scenarios followed by random traffic.
module tb_adder_result_stage;
  localparam int W  = 6;
  localparam int D  = 2;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [W-1:0]  in_sum;
  logic          in_ov;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_sum;
  logic          out_ov;
  logic          out_ready;
  logic          clr_cnt;
  logic [CW-1:0] ov_cnt;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [W-1:0] s;
    logic         o;
  } exp_t;

  exp_t exp_q[$];
  int   cnt_model = 0;

  always #5 clk = ~clk;

  adder_result_stage #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sum    (in_sum),
    .in_ov     (in_ov),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_sum   (out_sum),
    .out_ov    (out_ov),
    .out_ready (out_ready),
    .clr_cnt   (clr_cnt),
    .ov_cnt    (ov_cnt)
  );

  function automatic logic [W-1:0] model_sum(input logic [W-1:0] s, input logic o);
`ifdef ADDER_RESULT_SATURATE_EN
    return o ? W'((1 << W) - 1) : s;
`else
    return s;
`endif
  endfunction

  // Monitor and scoreboard: compare the settled state, then predict the coming edge.
  always @(negedge clk) begin
    int   occ;
    exp_t e;
    occ = exp_q.size();

    compared++;
    if (in_ready !== (occ < D)) begin
      mismatched++;
      $display("FAIL in_ready: got %0b expected %0b (t=%0t)", in_ready, (occ < D), $time);
    end
    compared++;
    if (out_valid !== (occ > 0)) begin
      mismatched++;
      $display("FAIL out_valid: got %0b expected %0b (t=%0t)", out_valid, (occ > 0), $time);
    end
    compared++;
    if (ov_cnt !== CW'(cnt_model)) begin
      mismatched++;
      $display("FAIL ov_cnt: got %0d expected %0d (t=%0t)", ov_cnt, cnt_model, $time);
    end

    if (out_valid === 1'b1 && out_ready && occ > 0) begin
      e = exp_q.pop_front();
      compared++;
      if (out_sum !== e.s || out_ov !== e.o) begin
        mismatched++;
        $display("FAIL data: got sum=%02h ov=%0b expected sum=%02h ov=%0b (t=%0t)",
                 out_sum, out_ov, e.s, e.o, $time);
      end else begin
        $display("pop  sum=%02h ov=%0b ov_cnt=%0d", out_sum, out_ov, ov_cnt);
      end
    end

    if (rst) begin
      exp_q.delete();
      cnt_model = 0;
    end else begin
      if (in_valid && occ < D) begin
        e.s = model_sum(in_sum, in_ov);
        e.o = in_ov;
        exp_q.push_back(e);
        $display("push sum=%02h ov=%0b", in_sum, in_ov);
      end
      if (clr_cnt) cnt_model = 0;
      else if (in_valid && occ < D && in_ov && cnt_model < (1 << CW) - 1) cnt_model++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold a result on the input until the stage takes it, with a bounded wait.
  task automatic send(input logic [W-1:0] s, input logic o);
    bit done = 1'b0;
    logic acc;
    in_valid = 1'b1;
    in_sum   = s;
    in_ov    = o;
    for (int n = 0; n < 50 && !done; n++) begin
      acc = in_ready;
      tick();
      done = acc;
    end
    compared++;
    if (!done) begin
      mismatched++;
      $display("FAIL send_timeout: got no accept expected accept within 50 cycles (sum=%02h)", s);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sum = '0; in_ov = 1'b0; out_ready = 1'b0; clr_cnt = 1'b0;
    tick(); tick();
    rst = 1'b0;
    repeat (5) tick();

    out_ready = 1'b1;
    send(6'h2A, 1'b0);
    in_valid = 1'b0;
    repeat (3) tick();

    out_ready = 1'b0;
    send(6'h01, 1'b0);
    send(6'h02, 1'b0);
    in_valid = 1'b1; in_sum = 6'h03; in_ov = 1'b0;
    repeat (3) tick();
    out_ready = 1'b1;
    send(6'h03, 1'b0);
    in_valid = 1'b0;
    repeat (4) tick();

    send(6'h05, 1'b1);
    in_valid = 1'b0;
    repeat (3) tick();

    for (int i = 0; i < 300; i++) send(W'($urandom), 1'b1);
    in_valid = 1'b0;
    tick();
    in_valid = 1'b1; in_ov = 1'b1; clr_cnt = 1'b1;
    tick();
    in_valid = 1'b0; clr_cnt = 1'b0;
    repeat (3) tick();

    for (int i = 0; i < 20; i++) send(W'($urandom), 1'b0);
    send(W'($urandom), 1'b1);
    in_valid = 1'b1; in_sum = 6'h11; in_ov = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    repeat (3) tick();

    for (int i = 0; i < 2000; i++) begin
      in_valid  = ($urandom % 2) == 0;
      in_sum    = W'($urandom);
      in_ov     = ($urandom % 3) == 0;
      out_ready = ($urandom % 4) != 0;
      clr_cnt   = ($urandom % 64) == 0;
      rst       = ($urandom % 500) == 0;
      tick();
    end

    in_valid = 1'b0; out_ready = 1'b1; clr_cnt = 1'b0; rst = 1'b0;
    repeat (6) tick();
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d results outstanding expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
